fcs_engine: RTL and testbench
=============================

FCS_ENGINE -- requirements
Module: fcs_engine

Interface
REQ-001 Parameter CRC_WIDTH, default 16, remainder/FCS width in bits.
REQ-002 Parameter POLY, default 16'h1021, generator polynomial with implicit MSB omitted, CRC_WIDTH bits.
REQ-003 Parameter INIT, default all-zeros, remainder value loaded at frame start, CRC_WIDTH bits.
REQ-004 Parameter MAX_LEN, default 1024, maximum frame payload length in bits.
REQ-005 Parameter MIN_LEN, default 64, minimum frame payload length in bits.
REQ-006 CLK  in  1  system clock, all state on rising edge.
REQ-007 RST  in  1  asynchronous active-low reset.
REQ-008 Start  in  1  frame-start request, sampled in IDLE only.
REQ-009 Mode  in  1  0 = generate (append FCS), 1 = check (verify received FCS).
REQ-010 Data_Size  in  $clog2(MAX_LEN+1)  payload length in bits, latched with Start.
REQ-011 Input_Valid  in  1  Input_Data carries a valid bit this cycle.
REQ-012 Input_Data  in  1  serial payload bit, MSB of frame first.
REQ-013 Input_Ready  out  1  engine accepts a bit this cycle.
REQ-014 OUT  out  1  serial FCS bit, MSB first.
REQ-015 Valid_OUT  out  1  OUT is valid.
REQ-016 Done  out  1  one-cycle end-of-frame pulse.
REQ-017 Busy  out  1  frame in progress.
REQ-018 Error  out  1  check-mode FCS mismatch, held until next accepted Start.
REQ-019 Size_Err  out  1  one-cycle pulse, rejected Data_Size.

Function
REQ-020 The FSM SHALL have states IDLE, CALC, SHIFT, CHECK, DONE.
REQ-021 In IDLE, Start with MIN_LEN <= Data_Size <= MAX_LEN SHALL latch Data_Size and Mode, load remainder with INIT, clear bit counter and Error, and go to CALC.
REQ-022 In IDLE, Start with Data_Size out of range SHALL pulse Size_Err for one cycle and remain in IDLE.
REQ-023 Start outside IDLE SHALL be ignored.
REQ-024 Input_Ready SHALL be 1 exactly in CALC and CHECK; a bit is accepted only when Input_Valid and Input_Ready are both 1.
REQ-025 Per accepted bit: fb = rem[MSB] XOR Input_Data; rem = {rem[CRC_WIDTH-2:0],0} XOR (fb ? POLY : 0); counter +1.
REQ-026 Cycles with Input_Valid=0 SHALL leave remainder and counter unchanged (stall, no latency penalty on resumption).
REQ-027 On acceptance of bit number Data_Size in CALC, the next state SHALL be SHIFT if Mode=0, CHECK if Mode=1; counter clears.
REQ-028 SHIFT SHALL drive OUT = rem[MSB] with Valid_OUT=1 for exactly CRC_WIDTH consecutive cycles, shifting rem left by one each cycle, then go to DONE.
REQ-029 CHECK SHALL accept exactly CRC_WIDTH further bits via REQ-025, then go to DONE; Error SHALL be set at that transition if rem != 0.
REQ-030 DONE SHALL last one cycle with Done=1, then return to IDLE.
REQ-031 Busy SHALL be 1 in every state except IDLE.
REQ-032 OUT SHALL be 0 whenever Valid_OUT = 0.
REQ-033 Counter width SHALL be $clog2(MAX_LEN+1); Data_Size = MAX_LEN SHALL complete without wrap.

Reset
REQ-034 RST low SHALL asynchronously force IDLE, remainder = INIT, counter = 0, and Input_Ready, OUT, Valid_OUT, Done, Busy, Error, Size_Err = 0.
REQ-035 Reset in any state mid-frame SHALL abort the frame with no Done pulse; the first Start after release SHALL behave as from power-up.

Structure
REQ-036 Package fcs_pkg SHALL hold the FSM state enumeration and default POLY/INIT constants.
REQ-037 Remainder update (REQ-025, plus load and left-shift controls) SHALL be a sub-module fcs_crc_core parametrised by CRC_WIDTH and POLY; FSM and counter stay in fcs_engine.

Verification
REQ-038 Generate, defaults, Data_Size=72, ASCII "123456789" continuous valid -> OUT serial 0x31C3 MSB first over 16 cycles with Valid_OUT=1, Done pulse next cycle.
REQ-039 Same payload with Input_Valid deasserted every other cycle -> identical 0x31C3 output, Done once.
REQ-040 Check mode, Data_Size=72, "123456789" followed by 16 bits 0x31C3 -> Done pulse, Error=0; flip payload bit 5 -> Error=1 held until next Start.
REQ-041 Start with Data_Size=63 and with 1025 -> Size_Err one-cycle pulse each, Busy stays 0; Data_Size=1024 all zeros -> OUT 0x0000, Done.
REQ-042 RST low during 8th SHIFT cycle -> all outputs 0 immediately, no Done; subsequent REQ-038 frame produces 0x31C3.
REQ-043 Start asserted while Busy=1 -> no effect on latched Data_Size, Mode or current result.

Source files
------------

// File: rtl/fcs_pkg.sv
// Shared types and default constants for the serial FCS engine.
package fcs_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CALC  = 3'd1,
    SHIFT = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } fcs_state_t;

  localparam logic [15:0] DEF_POLY = 16'h1021;
  localparam logic [15:0] DEF_INIT = 16'h0000;

endpackage

// File: rtl/fcs_crc_core.sv
// Bit-serial CRC remainder register: load INIT, absorb one bit, or shift out.
module fcs_crc_core
  import fcs_pkg::*;
#(
  parameter int                   CRC_WIDTH = 16,
  parameter logic [CRC_WIDTH-1:0] POLY      = DEF_POLY,
  parameter logic [CRC_WIDTH-1:0] INIT      = DEF_INIT
) (
  input  logic CLK,
  input  logic RST,
  input  logic load,
  input  logic step,
  input  logic shift,
  input  logic din,
  output logic rem_msb,
  output logic nxt_zero
);

  logic [CRC_WIDTH-1:0] rem_q, rem_d;
  logic                 fb;

  always_comb begin
    rem_d = rem_q;
    fb    = rem_q[CRC_WIDTH-1] ^ din;
    if (load)
      rem_d = INIT;
    else if (step)
      rem_d = {rem_q[CRC_WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
    else if (shift)
      rem_d = {rem_q[CRC_WIDTH-2:0], 1'b0};
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) rem_q <= INIT;
    else      rem_q <= rem_d;
  end

  assign rem_msb  = rem_q[CRC_WIDTH-1];
  // Lets the FSM judge the final check-mode remainder in the same cycle it is formed.
  assign nxt_zero = (rem_d == '0);

endmodule

// File: rtl/fcs_engine.sv
// Serial FCS generator/checker: frame length control, FSM and output framing.
module fcs_engine
  import fcs_pkg::*;
#(
  parameter int                   CRC_WIDTH = 16,
  parameter logic [CRC_WIDTH-1:0] POLY      = DEF_POLY,
  parameter logic [CRC_WIDTH-1:0] INIT      = DEF_INIT,
  parameter int                   MAX_LEN   = 1024,
  parameter int                   MIN_LEN   = 64,
  localparam int                  SW        = $clog2(MAX_LEN + 1)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          Start,
  input  logic          Mode,
  input  logic [SW-1:0] Data_Size,
  input  logic          Input_Valid,
  input  logic          Input_Data,
  output logic          Input_Ready,
  output logic          OUT,
  output logic          Valid_OUT,
  output logic          Done,
  output logic          Busy,
  output logic          Error,
  output logic          Size_Err
);

  localparam logic [SW-1:0] MIN_L    = SW'(MIN_LEN);
  localparam logic [SW-1:0] MAX_L    = SW'(MAX_LEN);
  localparam logic [SW-1:0] CRC_LAST = SW'(CRC_WIDTH - 1);

  fcs_state_t    state_q, state_d;
  logic [SW-1:0] cnt_q, cnt_d, size_q, size_d;
  logic          mode_q, mode_d, err_q, err_d, size_err_q, size_err_d;
  logic          load, step, shift, accept, rem_msb, nxt_zero;

  assign Input_Ready = (state_q == CALC) || (state_q == CHECK);
  assign accept      = Input_Valid && Input_Ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    size_d     = size_q;
    mode_d     = mode_q;
    err_d      = err_q;
    size_err_d = 1'b0;
    load       = 1'b0;
    step       = 1'b0;
    shift      = 1'b0;
    unique case (state_q)
      IDLE: if (Start) begin
        if (Data_Size >= MIN_L && Data_Size <= MAX_L) begin
          size_d  = Data_Size;
          mode_d  = Mode;
          load    = 1'b1;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = CALC;
        end else begin
          size_err_d = 1'b1;
        end
      end
      CALC: if (accept) begin
        step = 1'b1;
        if (cnt_q == size_q - SW'(1)) begin
          cnt_d   = '0;
          state_d = mode_q ? CHECK : SHIFT;
        end else begin
          cnt_d = cnt_q + SW'(1);
        end
      end
      SHIFT: begin
        shift = 1'b1;
        if (cnt_q == CRC_LAST) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + SW'(1);
        end
      end
      CHECK: if (accept) begin
        step = 1'b1;
        if (cnt_q == CRC_LAST) begin
          cnt_d   = '0;
          err_d   = !nxt_zero;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + SW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      size_q     <= '0;
      mode_q     <= 1'b0;
      err_q      <= 1'b0;
      size_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      size_q     <= size_d;
      mode_q     <= mode_d;
      err_q      <= err_d;
      size_err_q <= size_err_d;
    end
  end

  fcs_crc_core #(
    .CRC_WIDTH(CRC_WIDTH),
    .POLY     (POLY),
    .INIT     (INIT)
  ) u_core (
    .CLK     (CLK),
    .RST     (RST),
    .load    (load),
    .step    (step),
    .shift   (shift),
    .din     (Input_Data),
    .rem_msb (rem_msb),
    .nxt_zero(nxt_zero)
  );

  assign Valid_OUT = (state_q == SHIFT);
  assign OUT       = Valid_OUT && rem_msb;
  assign Done      = (state_q == DONE);
  assign Busy      = (state_q != IDLE);
  assign Error     = err_q;
  assign Size_Err  = size_err_q;

endmodule

// File: tb/tb_fcs_engine.sv
// Directed bench for fcs_engine: CRC-16/XMODEM vectors, stalls, check mode, limits, reset.
module tb_fcs_engine;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        Start = 1'b0;
  logic        Mode = 1'b0;
  logic [10:0] Data_Size = '0;
  logic        Input_Valid = 1'b0;
  logic        Input_Data = 1'b0;
  logic        Input_Ready, OUT, Valid_OUT, Done, Busy, Error, Size_Err;

  int n_tests = 0;
  int n_fail  = 0;

  fcs_engine dut (
    .CLK(CLK), .RST(RST), .Start(Start), .Mode(Mode), .Data_Size(Data_Size),
    .Input_Valid(Input_Valid), .Input_Data(Input_Data), .Input_Ready(Input_Ready),
    .OUT(OUT), .Valid_OUT(Valid_OUT), .Done(Done), .Busy(Busy), .Error(Error),
    .Size_Err(Size_Err)
  );

  always #5 CLK = ~CLK;

  // kind 0: "123456789" then FCS 0x31C3; kind 1: all zeros. flip < 0 disables corruption.
  function automatic logic pbit(int i, int kind, int flip);
    string       s = "123456789";
    logic [15:0] f = 16'h31C3;
    byte         b;
    logic        r;
    if (kind == 1) r = 1'b0;
    else if (i < 72) begin b = s[i/8]; r = b[7 - (i % 8)]; end
    else r = f[15 - (i - 72)];
    if (i == flip) r = ~r;
    return r;
  endfunction

  task automatic start_frame(input int size, input logic mode);
    Start = 1'b1; Data_Size = 11'(size); Mode = mode;
    @(negedge CLK);
    Start = 1'b0;
  endtask

  // noise: number of leading bits during which a conflicting Start is held high.
  task automatic feed(input int n, input int kind, input int gap, input int flip, input int noise);
    for (int i = 0; i < n; i++) begin
      Input_Valid = 1'b1;
      Input_Data  = pbit(i, kind, flip);
      if (i < noise) begin Start = 1'b1; Mode = 1'b1; Data_Size = 11'd200; end
      else Start = 1'b0;
      @(negedge CLK);
      if (gap != 0 && i < n - 1) begin
        Input_Valid = 1'b0; Input_Data = 1'b1;
        @(negedge CLK);
      end
    end
    Input_Valid = 1'b0; Input_Data = 1'b0; Start = 1'b0;
  endtask

  task automatic collect(output logic [15:0] word, output int nv, output int ndone,
                         output int last_v, output int done_c, output int leak);
    word = '0; nv = 0; ndone = 0; last_v = -1; done_c = -1; leak = 0;
    for (int c = 0; c < 40; c++) begin
      if (Valid_OUT) begin word = {word[14:0], OUT}; nv++; last_v = c; end
      else if (OUT) leak++;
      if (Done) begin ndone++; if (done_c < 0) done_c = c; end
      @(negedge CLK);
    end
  endtask

  task automatic test_reset;
    n_tests++;
    if ({Input_Ready, OUT, Valid_OUT, Done, Busy, Error, Size_Err} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%b want=0000000",
               {Input_Ready, OUT, Valid_OUT, Done, Busy, Error, Size_Err});
    end
    @(negedge CLK); RST = 1'b1; @(negedge CLK);
  endtask

  task automatic gen_frame(input string name, input int gap, input int noise);
    logic [15:0] w; int nv, nd, lv, dc, lk;
    start_frame(72, 1'b0);
    feed(72, 0, gap, -1, noise);
    collect(w, nv, nd, lv, dc, lk);
    n_tests++; if (w !== 16'h31C3) begin n_fail++; $display("FAIL %s_fcs got=%h want=31c3", name, w); end
    n_tests++; if (nv !== 16) begin n_fail++; $display("FAIL %s_nvalid got=%0d want=16", name, nv); end
    n_tests++; if (nd !== 1 || dc !== lv + 1) begin
      n_fail++; $display("FAIL %s_done got=%0d@%0d want=1@%0d", name, nd, dc, lv + 1);
    end
    n_tests++; if (lk !== 0) begin n_fail++; $display("FAIL %s_out_leak got=%0d want=0", name, lk); end
  endtask

  task automatic test_generate;    gen_frame("gen", 0, 0);   endtask
  task automatic test_stall;       gen_frame("stall", 1, 0); endtask
  task automatic test_start_busy;  gen_frame("busy_start", 0, 40); endtask

  task automatic test_check;
    logic [15:0] w; int nv, nd, lv, dc, lk;
    start_frame(72, 1'b1);
    feed(88, 0, 0, -1, 0);
    collect(w, nv, nd, lv, dc, lk);
    n_tests++; if (nd !== 1 || nv !== 0) begin
      n_fail++; $display("FAIL check_ok_done got=done%0d/valid%0d want=1/0", nd, nv);
    end
    n_tests++; if (Error !== 1'b0) begin n_fail++; $display("FAIL check_ok_error got=%b want=0", Error); end
    start_frame(72, 1'b1);
    feed(88, 0, 0, 5, 0);
    collect(w, nv, nd, lv, dc, lk);
    n_tests++; if (nd !== 1) begin n_fail++; $display("FAIL check_bad_done got=%0d want=1", nd); end
    n_tests++; if (Error !== 1'b1) begin n_fail++; $display("FAIL check_bad_error got=%b want=1", Error); end
    repeat (5) @(negedge CLK);
    n_tests++; if (Error !== 1'b1) begin n_fail++; $display("FAIL check_error_hold got=%b want=1", Error); end
    start_frame(72, 1'b1);
    n_tests++; if (Error !== 1'b0 || Busy !== 1'b1) begin
      n_fail++; $display("FAIL check_error_clear got=err%b/busy%b want=0/1", Error, Busy);
    end
    feed(88, 0, 0, -1, 0);
    collect(w, nv, nd, lv, dc, lk);
  endtask

  task automatic test_size_limits;
    logic [15:0] w; int nv, nd, lv, dc, lk;
    int bad [2] = '{63, 1025};
    foreach (bad[k]) begin
      start_frame(bad[k], 1'b0);
      n_tests++; if (Size_Err !== 1'b1 || Busy !== 1'b0) begin
        n_fail++; $display("FAIL size_err_%0d got=se%b/busy%b want=1/0", bad[k], Size_Err, Busy);
      end
      @(negedge CLK);
      n_tests++; if (Size_Err !== 1'b0 || Busy !== 1'b0) begin
        n_fail++; $display("FAIL size_err_pulse_%0d got=se%b/busy%b want=0/0", bad[k], Size_Err, Busy);
      end
    end
    start_frame(1024, 1'b0);
    feed(1024, 1, 0, -1, 0);
    collect(w, nv, nd, lv, dc, lk);
    n_tests++; if (w !== 16'h0000 || nv !== 16) begin
      n_fail++; $display("FAIL max_len_fcs got=%h/%0d want=0000/16", w, nv);
    end
    n_tests++; if (nd !== 1) begin n_fail++; $display("FAIL max_len_done got=%0d want=1", nd); end
  endtask

  task automatic test_reset_mid;
    int nd = 0;
    start_frame(72, 1'b0);
    feed(72, 0, 0, -1, 0);
    repeat (7) @(negedge CLK);
    n_tests++; if (Valid_OUT !== 1'b1) begin n_fail++; $display("FAIL mid_in_shift got=%b want=1", Valid_OUT); end
    RST = 1'b0;
    #1;
    n_tests++; if ({Input_Ready, OUT, Valid_OUT, Done, Busy, Error, Size_Err} !== 7'b0) begin
      n_fail++; $display("FAIL mid_reset_outputs got=%b want=0000000",
                         {Input_Ready, OUT, Valid_OUT, Done, Busy, Error, Size_Err});
    end
    for (int c = 0; c < 3; c++) begin @(negedge CLK); if (Done) nd++; end
    RST = 1'b1;
    for (int c = 0; c < 3; c++) begin @(negedge CLK); if (Done) nd++; end
    n_tests++; if (nd !== 0) begin n_fail++; $display("FAIL mid_reset_no_done got=%0d want=0", nd); end
    gen_frame("after_reset", 0, 0);
  endtask

  initial begin
    test_reset();
    test_generate();
    test_stall();
    test_check();
    test_size_limits();
    test_reset_mid();
    test_start_busy();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
